// File: rtl/temp_conv_pkg.sv
// Shared types and constants for the two-requester temperature conversion ROM arbiter.
package temp_conv_pkg;

  localparam int TEMP_W_DEFAULT = 8;
  localparam int NUM_REQ        = 2;

  typedef enum logic [1:0] {IDLE, WAIT, CAP, RESP} arb_state_t;
  typedef logic req_id_t;

  localparam logic FMT_F = 1'b1;
  localparam logic FMT_C = 1'b0;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(req_id_t id);
    logic [NUM_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/temp_conv_rom_arbiter_rr.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the one not served last.
module rr_arbiter2
  import temp_conv_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  req_id_t            i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_grant_valid,
  output req_id_t            o_grant_id
);

  always_comb begin
    o_grant = '0;
    unique case (i_req_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  assign o_grant_valid = |i_req_valid;
  assign o_grant_id    = o_grant[1];

endmodule

// File: rtl/temp_conv_rom_arbiter.sv
// Shares one CtoF/FtoC synchronous ROM pair between two requesters: grant, wait out
// the ROM latency, capture the selected ROM output and hold it until the owner accepts.
module temp_conv_rom_arbiter
  import temp_conv_pkg::*;
#(
  parameter int TEMP_W  = TEMP_W_DEFAULT,
  parameter int ROM_LAT = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][TEMP_W-1:0] req_temp,
  input  logic [NUM_REQ-1:0]             req_fmt,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [TEMP_W-1:0]              rsp_data,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [TEMP_W-1:0]              rom_addr,
  input  logic [TEMP_W-1:0]              rom_f_data,
  input  logic [TEMP_W-1:0]              rom_c_data,
  output logic                           busy
);

  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  arb_state_t          r_state;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [TEMP_W-1:0]   r_rsp_data;
  logic [TEMP_W-1:0]   r_rom_addr;
  logic                r_busy;
  logic [CNT_W-1:0]    r_wait_cnt;
  req_id_t             r_last_grant;
  logic                r_fmt_q;
  req_id_t             r_id_q;

  logic [NUM_REQ-1:0]  w_grant;
  logic                w_grant_valid;
  req_id_t             w_grant_id;

  rr_arbiter2 u_rr (
    .i_req_valid   (req_valid),
    .i_last_grant  (r_last_grant),
    .o_grant       (w_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  // Ready is only offered from IDLE and is forced low while reset is held.
  assign req_ready = (reset_n && (r_state == IDLE)) ? w_grant : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_rom_addr   <= '0;
      r_busy       <= 1'b0;
      r_wait_cnt   <= '0;
      r_last_grant <= 1'b1;
      r_fmt_q      <= FMT_C;
      r_id_q       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_rom_addr   <= req_temp[w_grant_id];
            r_fmt_q      <= req_fmt[w_grant_id];
            r_id_q       <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_wait_cnt   <= CNT_W'(ROM_LAT - 1);
            r_busy       <= 1'b1;
            r_state      <= WAIT;
          end
        end
        WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state <= CAP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        CAP: begin
          r_rsp_data  <= (r_fmt_q == FMT_F) ? rom_f_data : rom_c_data;
          r_rsp_valid <= id_to_onehot(r_id_q);
          r_state     <= RESP;
        end
        RESP: begin
          // Only the owner's rsp_ready can complete the transaction.
          if (rsp_ready[r_id_q]) begin
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rom_addr  = r_rom_addr;
  assign busy      = r_busy;

endmodule
